// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the MEM-stage data responder
package mem_pkg;

    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DATA_W = 32;
    localparam int CNT_W      = 4;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t ST_IDLE = 2'd0;
    localparam mem_state_t ST_WAIT = 2'd1;
    localparam mem_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/mem_sram_1rw.sv
// rtl/mem_sram_1rw.sv - single-port word RAM, synchronous write and registered read, no reset
module mem_sram_1rw #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // One access per enabled edge; the read register only moves on a read so it holds otherwise
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_data_responder.sv
// rtl/mem_data_responder.sv - MEM-stage data-memory responder with wait states and pipeline stall
module mem_data_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              wre_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done_out,
    output logic              stall_out
);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wre_q, wre_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              access;
    logic [DATA_W-1:0] sram_rdata;

    // The RAM is touched only on the last WAIT edge, so a reset before then discards the access
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);

    // Next-state logic: latch the request in IDLE, count down in WAIT, one DONE cycle, back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wre_d   = wre_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    addr_d  = addr_in;
                    wre_d   = wre_in;
                    wdata_d = wdata_in;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Keep the load result visible after DONE; req_in is ignored here
                if (!wre_q) begin
                    rdata_d = sram_rdata;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and latched-request state with asynchronous active-low clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wre_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wre_q   <= wre_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    mem_sram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sram (
        .clock (clock),
        .en    (access),
        .we    (wre_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (sram_rdata)
    );

    assign done_out  = (state_q == ST_DONE);
    assign stall_out = ((state_q == ST_IDLE) && req_in) || (state_q == ST_WAIT);
    // During a read's DONE cycle the fresh RAM word is shown directly; otherwise the held copy
    assign rdata_out = (done_out && !wre_q) ? sram_rdata : rdata_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// tb/tb_mem_data_responder.sv - self-checking bench for mem_data_responder
module tb_mem_data_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_v   [3];
    logic [6:0]  addr_v  [3];
    logic        wre_v   [3];
    logic [31:0] wdata_v [3];
    logic [31:0] rdata_v [3];
    logic        done_v  [3];
    logic        stall_v [3];

    int ws_of[3] = '{1, 0, 3};

    logic [31:0] ram_m   [3][128];
    bit          wr_m    [3][128];
    logic [31:0] last_rd [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        bit          we;
        logic [6:0]  a;
        logic [31:0] d;
        bit          rd_chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8] = '{
        '{0, 1'b1, 7'h05, 32'hDEADBEEF, 1'b0, 32'h0},
        '{0, 1'b0, 7'h05, 32'h0,        1'b1, 32'hDEADBEEF},
        '{1, 1'b1, 7'h00, 32'h11111111, 1'b0, 32'h0},
        '{1, 1'b1, 7'h7F, 32'h12345678, 1'b0, 32'h0},
        '{1, 1'b0, 7'h7F, 32'h0,        1'b1, 32'h12345678},
        '{1, 1'b0, 7'h00, 32'h0,        1'b1, 32'h11111111},
        '{2, 1'b1, 7'h40, 32'hC0FFEE00, 1'b0, 32'h0},
        '{2, 1'b0, 7'h40, 32'h0,        1'b1, 32'hC0FFEE00}
    };

    always #5 clock = ~clock;

    mem_data_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_STATES(1)) u_dut0 (
        .clock(clock), .reset(reset), .req_in(req_v[0]), .addr_in(addr_v[0]),
        .wre_in(wre_v[0]), .wdata_in(wdata_v[0]), .rdata_out(rdata_v[0]),
        .done_out(done_v[0]), .stall_out(stall_v[0]));

    mem_data_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_STATES(0)) u_dut1 (
        .clock(clock), .reset(reset), .req_in(req_v[1]), .addr_in(addr_v[1]),
        .wre_in(wre_v[1]), .wdata_in(wdata_v[1]), .rdata_out(rdata_v[1]),
        .done_out(done_v[1]), .stall_out(stall_v[1]));

    mem_data_responder #(.ADDR_W(7), .DATA_W(32), .WAIT_STATES(3)) u_dut2 (
        .clock(clock), .reset(reset), .req_in(req_v[2]), .addr_in(addr_v[2]),
        .wre_in(wre_v[2]), .wdata_in(wdata_v[2]), .rdata_out(rdata_v[2]),
        .done_out(done_v[2]), .stall_out(stall_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One complete access on instance k; latency and data come from the model, not the DUT
    task automatic access(input int k, input bit we, input logic [6:0] a, input logic [31:0] d,
                          input bit scramble, input bit hold, output logic [31:0] got);
        int n;
        bit seen;
        logic [31:0] exp;
        @(negedge clock);
        req_v[k] = 1'b1; wre_v[k] = we; addr_v[k] = a; wdata_v[k] = d;
        #1;
        chk("stall_on_req", {31'b0, stall_v[k]}, 32'd1);
        chk("done_in_idle", {31'b0, done_v[k]}, 32'd0);
        @(posedge clock);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            if (done_v[k]) begin
                seen = 1'b1;
            end else begin
                chk("stall_in_wait", {31'b0, stall_v[k]}, 32'd1);
                if (scramble) begin
                    addr_v[k] = 7'h10; wdata_v[k] = 32'hFFFFFFFF; wre_v[k] = ~we;
                end
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout inst=%0d actual=no_done required=done", k);
        end
        chk("latency", n, ws_of[k] + 2);
        chk("stall_in_done", {31'b0, stall_v[k]}, 32'd0);
        if (we) begin
            ram_m[k][a] = d;
            wr_m[k][a] = 1'b1;
            chk("rdata_hold_on_write", rdata_v[k], last_rd[k]);
        end else begin
            exp = ram_m[k][a];
            chk("read_data", rdata_v[k], exp);
            last_rd[k] = exp;
        end
        got = rdata_v[k];
        if (!hold) req_v[k] = 1'b0;
        @(posedge clock);
        #1;
        chk("done_single_pulse", {31'b0, done_v[k]}, 32'd0);
        chk("rdata_hold_idle", rdata_v[k], last_rd[k]);
    endtask

    initial begin
        logic [31:0] got;
        int          k;
        logic [6:0]  a;
        bit          we;

        for (int i = 0; i < 3; i++) begin
            req_v[i] = 1'b0; addr_v[i] = '0; wre_v[i] = 1'b0; wdata_v[i] = '0;
            last_rd[i] = '0;
            for (int j = 0; j < 128; j++) wr_m[i][j] = 1'b0;
        end

        // Reset then idle
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++) begin
                chk("reset_done", {31'b0, done_v[i]}, 32'd0);
                chk("reset_stall", {31'b0, stall_v[i]}, 32'd0);
                chk("reset_rdata", rdata_v[i], 32'd0);
            end
        end

        // Directed table: write/read pairs, boundary words 0x00 and 0x7F
        for (int i = 0; i < 8; i++) begin
            access(tbl[i].k, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0, 1'b0, got);
            if (tbl[i].rd_chk) chk("table_read", got, tbl[i].exp);
        end

        // Inputs moving during stall must not redirect a write
        access(0, 1'b1, 7'h10, 32'h55550010, 1'b0, 1'b0, got);
        access(0, 1'b1, 7'h03, 32'hA5A5A5A5, 1'b1, 1'b0, got);
        access(0, 1'b0, 7'h03, 32'h0, 1'b0, 1'b0, got);
        chk("stable_write_target", got, 32'hA5A5A5A5);
        access(0, 1'b0, 7'h10, 32'h0, 1'b0, 1'b0, got);
        chk("stable_other_word", got, 32'h55550010);

        // Reset during WAIT of a write discards it
        access(2, 1'b1, 7'h20, 32'h0BADF00D, 1'b0, 1'b0, got);
        @(negedge clock);
        req_v[2] = 1'b1; wre_v[2] = 1'b1; addr_v[2] = 7'h20; wdata_v[2] = 32'h1;
        @(posedge clock);
        @(negedge clock);
        chk("midwrite_wait_stall", {31'b0, stall_v[2]}, 32'd1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_done", {31'b0, done_v[2]}, 32'd0);
        chk("async_reset_stall_req", {31'b0, stall_v[2]}, 32'd1);
        chk("async_reset_rdata", rdata_v[0], 32'd0);
        req_v[2] = 1'b0;
        #1;
        chk("async_reset_stall", {31'b0, stall_v[2]}, 32'd0);
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clock);
            chk("no_done_after_abort", {31'b0, done_v[2]}, 32'd0);
        end
        access(2, 1'b0, 7'h20, 32'h0, 1'b0, 1'b0, got);
        chk("aborted_write_discarded", got, 32'h0BADF00D);

        // req_in held high across DONE: each access still pulses done once
        access(1, 1'b1, 7'h33, 32'hAAAA0001, 1'b0, 1'b1, got);
        access(1, 1'b1, 7'h34, 32'hAAAA0002, 1'b0, 1'b1, got);
        access(1, 1'b0, 7'h33, 32'h0, 1'b0, 1'b1, got);
        chk("chain_read_a", got, 32'hAAAA0001);
        access(1, 1'b0, 7'h34, 32'h0, 1'b0, 1'b0, got);
        chk("chain_read_b", got, 32'hAAAA0002);

        // Randomized accesses against the model; reads only of words already written
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       a = 7'h00;
                1:       a = 7'h7F;
                default: a = 7'($urandom_range(0, 127));
            endcase
            we = !wr_m[k][a] || ($urandom_range(0, 1) == 1);
            access(k, we, a, $urandom, ($urandom_range(0, 1) == 1), 1'b0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
